// File: rtl/bus_fifo_bank.sv
// Multi-channel FIFO bank: per channel, an agent-to-bus TX FIFO and a bus-to-agent RX FIFO,
// with occupancy, saturating drop counters and sticky underflow status.
module bus_fifo_bank #(
  parameter int unsigned drvrs    = 4,
  parameter int unsigned pckg_sz  = 16,
  parameter int unsigned depth    = 8,
  parameter int unsigned ovf_mode = 0,
  localparam int unsigned cw      = $clog2(depth) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [drvrs-1:0]           wr_en,
  input  logic [drvrs*pckg_sz-1:0]   wr_data,
  output logic [drvrs-1:0]           tx_full,
  output logic [drvrs-1:0]           pndng,
  input  logic [drvrs-1:0]           pop,
  output logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]           push,
  input  logic [drvrs*pckg_sz-1:0]   D_push,
  output logic [drvrs-1:0]           rx_valid,
  input  logic [drvrs-1:0]           rd_en,
  output logic [drvrs*pckg_sz-1:0]   rd_data,
  output logic [drvrs*cw-1:0]        tx_cnt,
  output logic [drvrs*cw-1:0]        rx_cnt,
  output logic [drvrs*8-1:0]         drop_cnt,
  output logic [drvrs-1:0]           underflow
);

  localparam int unsigned nf = 2 * drvrs;
  localparam int unsigned pw = $clog2(depth);

  // FIFO k < drvrs is TX of channel k; FIFO drvrs+c is RX of channel c.
  logic [nf-1:0]         f_wr, f_rd, f_ovf, f_under;
  logic [nf*pckg_sz-1:0] f_wdata, f_head;
  logic [nf*cw-1:0]      f_cnt;

  assign f_wr    = {push, wr_en};
  assign f_rd    = {rd_en, pop};
  assign f_wdata = {D_push, wr_data};

  for (genvar k = 0; k < nf; k++) begin : g_fifo
    logic [pckg_sz-1:0] mem [depth];
    logic [pw-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cw-1:0]      cnt_q, cnt_d;
    logic               wr, rd, full, empty;
    logic               rd_ok, wr_ok, ovf, ovw, mem_we;
    logic [pckg_sz-1:0] wdata;

    assign wr    = f_wr[k];
    assign rd    = f_rd[k];
    assign wdata = f_wdata[k*pckg_sz +: pckg_sz];
    assign full  = (cnt_q == cw'(depth));
    assign empty = (cnt_q == '0);

    // A read on a full FIFO frees the slot the concurrent write needs.
    assign rd_ok  = rd & ~empty;
    assign wr_ok  = wr & (~full | rd_ok);
    assign ovf    = wr & full & ~rd;
    assign ovw    = ovf & (ovf_mode != 0);
    assign mem_we = wr_ok | ovw;

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (mem_we) begin
        wptr_d = wptr_q + 1'b1;
      end
      // When full the head slot equals the write slot, so overwrite drops the oldest entry.
      if (rd_ok | ovw) begin
        rptr_d = rptr_q + 1'b1;
      end
      if (wr_ok & ~rd_ok) begin
        cnt_d = cnt_q + 1'b1;
      end else if (rd_ok & ~wr_ok) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[wptr_q] <= wdata;
      end
    end

    assign f_head[k*pckg_sz +: pckg_sz] = empty ? '0 : mem[rptr_q];
    assign f_cnt[k*cw +: cw]            = cnt_q;
    assign f_ovf[k]                     = ovf;
    assign f_under[k]                   = rd & empty;
  end

  for (genvar c = 0; c < drvrs; c++) begin : g_chan
    logic [7:0] drop_q, drop_d;
    logic [8:0] drop_sum;
    logic       under_q;
    logic [cw-1:0] tcnt, rcnt;

    assign tcnt = f_cnt[c*cw +: cw];
    assign rcnt = f_cnt[(drvrs+c)*cw +: cw];

    always_comb begin
      drop_sum = {1'b0, drop_q} + {8'd0, f_ovf[c]} + {8'd0, f_ovf[drvrs+c]};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        drop_q  <= '0;
        under_q <= 1'b0;
      end else begin
        drop_q  <= drop_d;
        under_q <= under_q | f_under[c] | f_under[drvrs+c];
      end
    end

    assign drop_cnt[c*8 +: 8] = drop_q;
    assign underflow[c]       = under_q;
    assign tx_full[c]         = (tcnt == cw'(depth));
    assign pndng[c]           = (tcnt != '0);
    assign rx_valid[c]        = (rcnt != '0);
  end

  assign D_pop   = f_head[drvrs*pckg_sz-1:0];
  assign rd_data = f_head[nf*pckg_sz-1:drvrs*pckg_sz];
  assign tx_cnt  = f_cnt[drvrs*cw-1:0];
  assign rx_cnt  = f_cnt[nf*cw-1:drvrs*cw];

endmodule

// File: tb/tb_bus_fifo_bank.sv
// Bench for bus_fifo_bank: a drop-mode and an overwrite-mode instance share stimulus;
// queue models per channel predict every drained packet.
module tb_bus_fifo_bank;
  localparam int DRVRS = 4;
  localparam int PSZ   = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DRVRS-1:0]     wr_en, pop, push, rd_en;
  logic [DRVRS*PSZ-1:0] wr_data, D_push;

  logic [DRVRS-1:0]     a_tx_full, a_pndng, a_rx_valid, a_underflow;
  logic [DRVRS*PSZ-1:0] a_D_pop, a_rd_data;
  logic [DRVRS*CW-1:0]  a_tx_cnt, a_rx_cnt;
  logic [DRVRS*8-1:0]   a_drop_cnt;
  logic [DRVRS-1:0]     b_tx_full, b_pndng, b_rx_valid, b_underflow;
  logic [DRVRS*PSZ-1:0] b_D_pop, b_rd_data;
  logic [DRVRS*CW-1:0]  b_tx_cnt, b_rx_cnt;
  logic [DRVRS*8-1:0]   b_drop_cnt;

  int errors = 0;
  int checks = 0;

  // a: drop-incoming model, b: overwrite-oldest model
  logic [PSZ-1:0] sb_a [DRVRS][$];
  logic [PSZ-1:0] sb_b [DRVRS][$];
  logic [PSZ-1:0] rx_a [DRVRS][$];
  logic [PSZ-1:0] rx_b [DRVRS][$];
  int exp_drop [DRVRS];

  bus_fifo_bank #(.drvrs(DRVRS), .pckg_sz(PSZ), .depth(DEPTH), .ovf_mode(0)) u_drop (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_full(a_tx_full),
    .pndng(a_pndng), .pop(pop), .D_pop(a_D_pop), .push(push), .D_push(D_push),
    .rx_valid(a_rx_valid), .rd_en(rd_en), .rd_data(a_rd_data), .tx_cnt(a_tx_cnt),
    .rx_cnt(a_rx_cnt), .drop_cnt(a_drop_cnt), .underflow(a_underflow)
  );

  bus_fifo_bank #(.drvrs(DRVRS), .pckg_sz(PSZ), .depth(DEPTH), .ovf_mode(1)) u_ovw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_full(b_tx_full),
    .pndng(b_pndng), .pop(pop), .D_pop(b_D_pop), .push(push), .D_push(D_push),
    .rx_valid(b_rx_valid), .rd_en(rd_en), .rd_data(b_rd_data), .tx_cnt(b_tx_cnt),
    .rx_cnt(b_rx_cnt), .drop_cnt(b_drop_cnt), .underflow(b_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_tx(input int ch, input logic [PSZ-1:0] d);
    logic [PSZ-1:0] tmp;
    if (sb_a[ch].size() < DEPTH) sb_a[ch].push_back(d);
    else exp_drop[ch]++;
    if (sb_b[ch].size() == DEPTH) tmp = sb_b[ch].pop_front();
    sb_b[ch].push_back(d);
  endfunction

  function automatic void model_rx(input int ch, input logic [PSZ-1:0] d);
    logic [PSZ-1:0] tmp;
    if (rx_a[ch].size() < DEPTH) rx_a[ch].push_back(d);
    else exp_drop[ch]++;
    if (rx_b[ch].size() == DEPTH) tmp = rx_b[ch].pop_front();
    rx_b[ch].push_back(d);
  endfunction

  task automatic write_tx(input int ch, input logic [PSZ-1:0] d);
    wr_en[ch] = 1'b1;
    wr_data[ch*PSZ +: PSZ] = d;
    model_tx(ch, d);
    tick();
    wr_en[ch] = 1'b0;
  endtask

  task automatic drain_tx(input int ch);
    logic [PSZ-1:0] ea, eb;
    int guard;
    guard = 0;
    while (sb_a[ch].size() > 0 && guard < 2 * DEPTH) begin
      checks++;
      if (a_tx_cnt[ch*CW +: CW] !== CW'(sb_a[ch].size())) begin
        errors++;
        $display("FAIL tx_cnt ch%0d: got %0d want %0d", ch, a_tx_cnt[ch*CW +: CW],
                 sb_a[ch].size());
      end
      ea = sb_a[ch].pop_front();
      checks++;
      if (a_D_pop[ch*PSZ +: PSZ] !== ea) begin
        errors++;
        $display("FAIL drain_drop ch%0d: got %h want %h", ch, a_D_pop[ch*PSZ +: PSZ], ea);
      end
      if (sb_b[ch].size() > 0) begin
        eb = sb_b[ch].pop_front();
        checks++;
        if (b_D_pop[ch*PSZ +: PSZ] !== eb) begin
          errors++;
          $display("FAIL drain_ovw ch%0d: got %h want %h", ch, b_D_pop[ch*PSZ +: PSZ], eb);
        end
      end
      pop[ch] = 1'b1;
      tick();
      pop[ch] = 1'b0;
      guard++;
    end
    checks++;
    if (a_pndng[ch] !== 1'b0 || b_pndng[ch] !== 1'b0 || a_tx_cnt[ch*CW +: CW] !== '0
        || a_D_pop[ch*PSZ +: PSZ] !== '0) begin
      errors++;
      $display("FAIL tx_empty ch%0d: got pndng=%b/%b cnt=%0d data=%h want 0", ch,
               a_pndng[ch], b_pndng[ch], a_tx_cnt[ch*CW +: CW], a_D_pop[ch*PSZ +: PSZ]);
    end
  endtask

  task automatic drain_rx(input int ch);
    logic [PSZ-1:0] ea, eb;
    int guard;
    guard = 0;
    while (rx_a[ch].size() > 0 && guard < 2 * DEPTH) begin
      ea = rx_a[ch].pop_front();
      eb = rx_b[ch].pop_front();
      checks++;
      if (a_rd_data[ch*PSZ +: PSZ] !== ea || b_rd_data[ch*PSZ +: PSZ] !== eb) begin
        errors++;
        $display("FAIL drain_rx ch%0d: got %h/%h want %h/%h", ch, a_rd_data[ch*PSZ +: PSZ],
                 b_rd_data[ch*PSZ +: PSZ], ea, eb);
      end
      rd_en[ch] = 1'b1;
      tick();
      rd_en[ch] = 1'b0;
      guard++;
    end
    checks++;
    if (a_rx_valid[ch] !== 1'b0 || a_rx_cnt[ch*CW +: CW] !== '0
        || a_rd_data[ch*PSZ +: PSZ] !== '0) begin
      errors++;
      $display("FAIL rx_empty ch%0d: got valid=%b cnt=%0d data=%h want 0", ch, a_rx_valid[ch],
               a_rx_cnt[ch*CW +: CW], a_rd_data[ch*PSZ +: PSZ]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (a_pndng !== '0 || a_rx_valid !== '0 || a_tx_full !== '0 || a_D_pop !== '0
        || a_rd_data !== '0 || a_tx_cnt !== '0 || a_rx_cnt !== '0 || a_drop_cnt !== '0
        || a_underflow !== '0 || b_pndng !== '0 || b_D_pop !== '0) begin
      errors++;
      $display("FAIL reset_state: got pndng=%h valid=%h full=%h dpop=%h cnt=%h drop=%h und=%h want 0",
               a_pndng, a_rx_valid, a_tx_full, a_D_pop, a_tx_cnt, a_drop_cnt, a_underflow);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    write_tx(0, 16'h1234);
    checks++;
    if (a_pndng[0] !== 1'b1 || a_tx_cnt[CW-1:0] !== 4'd1 || a_D_pop[PSZ-1:0] !== 16'h1234) begin
      errors++;
      $display("FAIL first_write: got pndng=%b cnt=%0d data=%h want 1 1 1234", a_pndng[0],
               a_tx_cnt[CW-1:0], a_D_pop[PSZ-1:0]);
    end
    write_tx(0, 16'h5678);
    checks++;
    if (a_pndng[DRVRS-1:1] !== '0 || a_rx_valid !== '0 || a_D_pop[DRVRS*PSZ-1:PSZ] !== '0) begin
      errors++;
      $display("FAIL idle_channels: got pndng=%b rx_valid=%b want 000 0", a_pndng[DRVRS-1:1],
               a_rx_valid);
    end
    drain_tx(0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) write_tx(1, PSZ'(i));
    checks++;
    if (a_tx_full[1] !== 1'b1 || b_tx_full[1] !== 1'b1 || a_tx_cnt[CW +: CW] !== 4'd8) begin
      errors++;
      $display("FAIL ovf_full: got full=%b/%b cnt=%0d want 1/1 8", a_tx_full[1], b_tx_full[1],
               a_tx_cnt[CW +: CW]);
    end
    checks++;
    if (a_drop_cnt[8 +: 8] !== 8'(exp_drop[1]) || b_drop_cnt[8 +: 8] !== 8'(exp_drop[1])) begin
      errors++;
      $display("FAIL ovf_drop_cnt: got %0d/%0d want %0d", a_drop_cnt[8 +: 8],
               b_drop_cnt[8 +: 8], exp_drop[1]);
    end
    checks++;
    if (a_D_pop[PSZ +: PSZ] !== 16'h0001 || b_D_pop[PSZ +: PSZ] !== 16'h0002) begin
      errors++;
      $display("FAIL ovf_head: got %h/%h want 0001/0002", a_D_pop[PSZ +: PSZ],
               b_D_pop[PSZ +: PSZ]);
    end
    drain_tx(1);
  endtask

  task automatic test_full_rw();
    logic [PSZ-1:0] ea, eb;
    for (int i = 0; i < DEPTH; i++) write_tx(2, 16'h2000 + PSZ'(i));
    ea = sb_a[2].pop_front();
    eb = sb_b[2].pop_front();
    checks++;
    if (a_tx_full[2] !== 1'b1 || a_D_pop[2*PSZ +: PSZ] !== ea || b_D_pop[2*PSZ +: PSZ] !== eb) begin
      errors++;
      $display("FAIL full_head: got full=%b data=%h/%h want 1 %h/%h", a_tx_full[2],
               a_D_pop[2*PSZ +: PSZ], b_D_pop[2*PSZ +: PSZ], ea, eb);
    end
    wr_en[2] = 1'b1;
    pop[2] = 1'b1;
    wr_data[2*PSZ +: PSZ] = 16'hAAAA;
    model_tx(2, 16'hAAAA);
    tick();
    wr_en[2] = 1'b0;
    pop[2] = 1'b0;
    checks++;
    if (a_tx_cnt[2*CW +: CW] !== 4'd8 || a_drop_cnt[16 +: 8] !== 8'(exp_drop[2])
        || b_drop_cnt[16 +: 8] !== 8'(exp_drop[2])) begin
      errors++;
      $display("FAIL full_rw: got cnt=%0d drop=%0d/%0d want 8 %0d", a_tx_cnt[2*CW +: CW],
               a_drop_cnt[16 +: 8], b_drop_cnt[16 +: 8], exp_drop[2]);
    end
    drain_tx(2);
  endtask

  task automatic test_dual_drop();
    for (int i = 0; i <= DEPTH; i++) begin
      wr_en[0] = 1'b1;
      push[0] = 1'b1;
      wr_data[PSZ-1:0] = 16'h0100 + PSZ'(i);
      D_push[PSZ-1:0] = 16'h0200 + PSZ'(i);
      model_tx(0, 16'h0100 + PSZ'(i));
      model_rx(0, 16'h0200 + PSZ'(i));
      tick();
    end
    wr_en[0] = 1'b0;
    push[0] = 1'b0;
    checks++;
    if (a_drop_cnt[7:0] !== 8'(exp_drop[0]) || b_drop_cnt[7:0] !== 8'(exp_drop[0])
        || a_rx_cnt[CW-1:0] !== 4'd8) begin
      errors++;
      $display("FAIL dual_drop: got drop=%0d/%0d rx_cnt=%0d want %0d 8", a_drop_cnt[7:0],
               b_drop_cnt[7:0], a_rx_cnt[CW-1:0], exp_drop[0]);
    end
    drain_tx(0);
    drain_rx(0);
  endtask

  task automatic test_underflow();
    push[3] = 1'b1;
    rd_en[3] = 1'b1;
    D_push[3*PSZ +: PSZ] = 16'hBEEF;
    model_rx(3, 16'hBEEF);
    tick();
    push[3] = 1'b0;
    rd_en[3] = 1'b0;
    checks++;
    if (a_underflow !== 4'b1000 || a_rx_cnt[3*CW +: CW] !== 4'd1
        || a_rd_data[3*PSZ +: PSZ] !== 16'hBEEF || a_rx_valid[3] !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: got und=%b cnt=%0d data=%h want 1000 1 beef", a_underflow,
               a_rx_cnt[3*CW +: CW], a_rd_data[3*PSZ +: PSZ]);
    end
    drain_rx(3);
    repeat (3) tick();
    checks++;
    if (a_underflow[3] !== 1'b1 || b_underflow[3] !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: got %b/%b want 1/1", a_underflow[3], b_underflow[3]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) write_tx(0, 16'h0050 + PSZ'(i));
    checks++;
    if (a_tx_cnt[CW-1:0] !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_cnt: got %0d want 5", a_tx_cnt[CW-1:0]);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (a_pndng !== '0 || a_tx_cnt !== '0 || a_D_pop !== '0 || a_underflow !== '0
        || a_drop_cnt !== '0 || a_tx_full !== '0 || a_rx_valid !== '0 || b_pndng !== '0) begin
      errors++;
      $display("FAIL async_reset: got pndng=%b cnt=%h dpop=%h und=%b drop=%h want 0", a_pndng,
               a_tx_cnt, a_D_pop, a_underflow, a_drop_cnt);
    end
    for (int c = 0; c < DRVRS; c++) begin
      sb_a[c].delete();
      sb_b[c].delete();
      rx_a[c].delete();
      rx_b[c].delete();
      exp_drop[c] = 0;
    end
    #2;
    rst = 1'b1;
    write_tx(0, 16'h00FF);
    checks++;
    if (a_D_pop[PSZ-1:0] !== 16'h00FF || a_tx_cnt[CW-1:0] !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_write: got data=%h cnt=%0d want 00ff 1", a_D_pop[PSZ-1:0],
               a_tx_cnt[CW-1:0]);
    end
    drain_tx(0);
  endtask

  initial begin
    wr_en = '0;
    pop = '0;
    push = '0;
    rd_en = '0;
    wr_data = '0;
    D_push = '0;
    for (int c = 0; c < DRVRS; c++) exp_drop[c] = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_dual_drop();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
